// File: rtl/uint8_pkg.sv
// Shared definitions for the uint8 row-drain datapath.
//   U8_W         : width of one uint8 lane
//   state_t      : drain FSM encoding (ST_IDLE / ST_DRAIN)
//   LANE_MSB_OFS : offset of a lane's MSB inside its 8-bit slice of a row
package uint8_pkg;

  localparam int U8_W = 8;

  localparam int LANE_MSB_OFS = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/uint8_lane_sel.sv
// Combinational N-to-1 byte mux: picks lane 'idx' out of a packed row.
// Lane k occupies row[8k +: 8], with bit 8k as the lane MSB.
// Ports:
//   row  : N packed uint8 lanes
//   idx  : lane select (values >= N return 0)
//   lane : selected byte, bit 0 is the MSB
module uint8_lane_sel
  import uint8_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = 4
) (
  input  logic [0:U8_W*N-1] row,
  input  logic [IDXW-1:0]   idx,
  output logic [0:U8_W-1]   lane
);

  always_comb begin
    lane = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IDXW'(k)) begin
        lane = row[U8_W*k + LANE_MSB_OFS +: U8_W];
      end
    end
  end

endmodule

// File: rtl/uint8_row_drain.sv
// Row drain: accepts one row of N uint8 lanes in a single load handshake
// and streams the lanes out one byte per valid/ready beat, lane 0 first.
// Optional build macro UINT8_ROW_DRAIN_SHADOW_EN adds a one-row shadow
// buffer so a following row can be queued during a drain and emitted with
// no bubble cycle.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   load_valid / load_ready : row load handshake, row_in sampled on it
//   row_in                  : N lanes, lane k = row_in[8k +: 8], bit 8k MSB
//   out_valid / out_ready   : beat handshake
//   out_data                : current lane byte (bit 0 MSB)
//   out_idx                 : current lane number, zero-extended
//   out_last                : current beat is lane N-1
module uint8_row_drain
  import uint8_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [0:8*N-1]    row_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:7]        out_data,
  output logic [0:IDXW-1]   out_idx,
  output logic              out_last
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  state_t              state_q, state_d;
  logic [IDXW-1:0]     cnt_q, cnt_d;
  logic [0:U8_W*N-1]   row_q, row_d;
  logic [0:U8_W-1]     lane_byte;
  logic                load_hs;
  logic                beat_hs;
  logic                at_last;

`ifdef UINT8_ROW_DRAIN_SHADOW_EN
  logic [0:U8_W*N-1]   shadow_q, shadow_d;
  logic                shadow_full_q, shadow_full_d;
`endif

  uint8_lane_sel #(
    .N    (N),
    .IDXW (IDXW)
  ) u_lane_sel (
    .row  (row_q),
    .idx  (cnt_q),
    .lane (lane_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

`ifdef UINT8_ROW_DRAIN_SHADOW_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
    end
  end
`endif

  // Outputs are gated by DRAIN so idle cycles present zeros, not stale lanes.
  always_comb begin
    out_valid = (state_q == ST_DRAIN);
    at_last   = (cnt_q == LAST_IDX);
    out_data  = out_valid ? lane_byte : '0;
    out_idx   = out_valid ? cnt_q : '0;
    out_last  = out_valid & at_last;
`ifdef UINT8_ROW_DRAIN_SHADOW_EN
    load_ready = !shadow_full_q;
`else
    load_ready = (state_q == ST_IDLE);
`endif
    load_hs = load_valid & load_ready;
    beat_hs = out_valid & out_ready;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
`ifdef UINT8_ROW_DRAIN_SHADOW_EN
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (load_hs) begin
          row_d   = row_in;
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
`ifdef UINT8_ROW_DRAIN_SHADOW_EN
        // On the last beat the next row (queued or arriving right now)
        // becomes active without leaving DRAIN, so no bubble is inserted.
        // A load can never coincide with a full shadow since load_ready=0.
        if (beat_hs && at_last) begin
          cnt_d = '0;
          if (shadow_full_q) begin
            row_d         = shadow_q;
            shadow_full_d = 1'b0;
          end else if (load_hs) begin
            row_d = row_in;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (beat_hs) begin
            cnt_d = cnt_q + IDXW'(1);
          end
          if (load_hs) begin
            shadow_d      = row_in;
            shadow_full_d = 1'b1;
          end
        end
`else
        if (beat_hs) begin
          if (at_last) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + IDXW'(1);
          end
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
